// File: rtl/stream_demux.sv
// stream_demux: registered valid/ready demultiplexer with packet locking.
// Each channel owns a one-entry output slot; a packet's first beat picks the
// channel and the rest of the packet follows it. Out-of-range targets are
// accepted and discarded.
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN adds the drop_count port.
module stream_demux #(
   parameter int WIDTH        = 16,
   parameter int SELECT_WIDTH = 3,
   parameter int CHANNELS     = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   input  logic [SELECT_WIDTH-1:0] in_index,
   input  logic                    in_last,
   output logic [CHANNELS-1:0]     out_valid,
   input  logic [CHANNELS-1:0]     out_ready,
   output logic [WIDTH-1:0]        out_data [CHANNELS],
   output logic [CHANNELS-1:0]     out_last,
   output logic                    busy
`ifdef STREAM_DEMUX_DROP_CNT_EN
   ,
   output logic [15:0]             drop_count
`endif
);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [SELECT_WIDTH-1:0] r_lock_sel;

   logic [SELECT_WIDTH-1:0] w_target;
   logic                    w_target_ok;
   logic                    w_target_free;
   logic                    w_accept;
   logic                    w_drop;
   logic [CHANNELS-1:0]     w_free;
   logic [CHANNELS-1:0]     w_hit;
   logic [CHANNELS-1:0]     w_load;

   // While locked the header's channel is reused; in_index is ignored.
   assign w_target    = (r_state == ST_LOCKED) ? r_lock_sel : in_index;
   assign w_target_ok = (32'(w_target) < 32'(CHANNELS));

   // A slot can take a beat if empty or being drained this same cycle.
   assign w_free = ~out_valid | out_ready;

   // One-hot decode of the target and the free flag of the selected slot.
   always_comb begin
      w_hit         = '0;
      w_target_free = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (w_target == SELECT_WIDTH'(c)) begin
            w_hit[c]      = 1'b1;
            w_target_free = w_free[c];
         end
      end
   end

   // Invalid targets are always accepted so a bad packet cannot wedge the input.
   assign in_ready = reset_n & (w_target_ok ? w_target_free : 1'b1);
   assign w_accept = in_valid & in_ready;
   assign w_drop   = w_accept & ~w_target_ok;
   assign w_load   = w_hit & {CHANNELS{w_accept & w_target_ok}};
   assign busy     = (r_state == ST_LOCKED);

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
      logic             r_valid;
      logic             r_last;
      logic [WIDTH-1:0] r_data;

      // Slot register: load an accepted beat, otherwise empty once drained.
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
         end else if (w_load[gi]) begin
            r_valid <= 1'b1;
            r_last  <= in_last;
            r_data  <= in_data;
         end else if (out_ready[gi]) begin
            r_valid <= 1'b0;
         end
      end

      assign out_valid[gi] = r_valid;
      assign out_last[gi]  = r_last;
      assign out_data[gi]  = r_data;
   end

   // State register and the channel captured from the packet header.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_lock_sel <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_IDLE && w_accept && !in_last) begin
            r_lock_sel <= in_index;
         end
      end
   end

   // Next state: lock on a multi-beat header, unlock on the accepted last beat.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && !in_last) w_state_next = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (w_accept && in_last) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

`ifdef STREAM_DEMUX_DROP_CNT_EN
   logic [15:0] r_drop_count;

   // Saturating count of discarded beats.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_drop_count <= '0;
      end else if (w_drop && r_drop_count != 16'hFFFF) begin
         r_drop_count <= r_drop_count + 16'd1;
      end
   end

   assign drop_count = r_drop_count;
`else
   logic w_drop_unused;
   assign w_drop_unused = w_drop;
`endif

endmodule
